// File: rtl/rr_arb_mux.sv
// Multi-channel arbiter feeding a single registered output stage.
// Grant is fixed priority (mode 0) or round-robin after the last winner (mode 1).
module rr_arb_mux #(
    parameter int unsigned size = 32,
    parameter int unsigned ch   = 3,
    parameter int unsigned mode = 1,
    localparam int unsigned selw = (ch > 2) ? $clog2(ch) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ch*size-1:0]  data_i,
    input  logic [ch-1:0]       valid_i,
    output logic [ch-1:0]       ready_o,
    input  logic                flush_i,
    output logic [size-1:0]     data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [selw-1:0]     sel_o
);

    logic            ld;
    logic            gv;
    logic            found;
    int              idx;
    logic [selw-1:0] gnt;
    logic [size-1:0] gnt_data;

    logic            valid_q, valid_d;
    logic [size-1:0] data_q, data_d;
    logic [selw-1:0] sel_q, sel_d;
    logic [selw-1:0] ptr_q, ptr_d;

    assign gv = |valid_i;
    assign ld = (~valid_q | ready_i) & ~flush_i;

    // Search order starts one past the last winner; mode 0 always starts at channel 0.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < int'(ch); i++) begin
            if (mode == 1) begin
                idx = (int'(ptr_q) + 1 + i) % int'(ch);
            end else begin
                idx = i;
            end
            if (!found && valid_i[idx[selw-1:0]]) begin
                found = 1'b1;
                gnt   = idx[selw-1:0];
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < int'(ch); k++) begin
            if (gnt == selw'(k)) begin
                gnt_data = data_i[k*size +: size];
            end
        end
    end

    // Accept is suppressed while reset is held so no upstream beat is lost.
    always_comb begin
        ready_o = '0;
        if (rst_i && ld && gv) begin
            ready_o[gnt] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ld) begin
            valid_d = gv;
            if (gv) begin
                data_d = gnt_data;
                sel_d  = gnt;
                if (mode == 1) begin
                    ptr_d = gnt;
                end
            end
        end
    end

    // ptr resets to the last channel so the first round-robin grant is channel 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= selw'(ch - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sel_o   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux (ch=3, size=8): one round-robin and one fixed-priority instance
// share stimulus; a behavioural model tracks both, plus a directed vector table.
module tb_rr_arb_mux;

    localparam logic [23:0] D0 = 24'h332211;
    localparam logic [23:0] D1 = 24'h33AA11;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] din;
    logic [2:0]  vin;
    logic        flush;
    logic        rdy;

    logic [2:0] ready1, ready0;
    logic [7:0] dout1, dout0;
    logic       vout1, vout0;
    logic [1:0] sel1, sel0;

    always #5 clk = ~clk;

    rr_arb_mux #(.size(8), .ch(3), .mode(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vin), .ready_o(ready1),
        .flush_i(flush), .data_o(dout1), .valid_o(vout1), .ready_i(rdy), .sel_o(sel1)
    );

    rr_arb_mux #(.size(8), .ch(3), .mode(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vin), .ready_o(ready0),
        .flush_i(flush), .data_o(dout0), .valid_o(vout0), .ready_i(rdy), .sel_o(sel0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, indexed by mode.
    int         m_valid[2];
    logic [7:0] m_data[2];
    int         m_sel[2];
    int         m_ptr[2];

    logic [2:0] smp_ready0, smp_ready1;

    typedef struct {
        logic [2:0]  v;
        logic        r;
        logic        f;
        logic [23:0] d;
        logic [2:0]  e_ready;
        logic        e_valid;
        logic [1:0]  e_sel;
        logic [7:0]  e_data;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant(input int md, input logic [2:0] v, input int p);
        int c;
        if (v == 3'b000) return -1;
        for (int off = 0; off < 3; off++) begin
            c = (md == 1) ? (p + 1 + off) % 3 : off;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int md = 0; md < 2; md++) begin
            m_valid[md] = 0;
            m_data[md]  = 8'h00;
            m_sel[md]   = 0;
            m_ptr[md]   = 2;
        end
    endtask

    // Called just after a rising edge with inputs applied; checks at the falling edge.
    task automatic tick();
        int         g;
        bit         ld;
        logic [2:0] er;
        int         n_valid[2];
        logic [7:0] n_data[2];
        int         n_sel[2];
        int         n_ptr[2];
        @(negedge clk);
        smp_ready0 = ready0;
        smp_ready1 = ready1;
        for (int md = 0; md < 2; md++) begin
            g  = grant(md, vin, m_ptr[md]);
            ld = (m_valid[md] == 0 || rdy) && !flush;
            er = (ld && g >= 0) ? 3'(1 << g) : 3'b000;
            chk(md ? "rr ready_o" : "fp ready_o", md ? 32'(ready1) : 32'(ready0), 32'(er));
            chk(md ? "rr valid_o" : "fp valid_o", md ? 32'(vout1) : 32'(vout0), 32'(m_valid[md]));
            chk(md ? "rr data_o" : "fp data_o", md ? 32'(dout1) : 32'(dout0), 32'(m_data[md]));
            chk(md ? "rr sel_o" : "fp sel_o", md ? 32'(sel1) : 32'(sel0), 32'(m_sel[md]));
            n_valid[md] = m_valid[md];
            n_data[md]  = m_data[md];
            n_sel[md]   = m_sel[md];
            n_ptr[md]   = m_ptr[md];
            if (flush) begin
                n_valid[md] = 0;
            end else if (ld) begin
                if (g >= 0) begin
                    n_valid[md] = 1;
                    n_data[md]  = din[g*8 +: 8];
                    n_sel[md]   = g;
                    if (md == 1) n_ptr[md] = g;
                end else begin
                    n_valid[md] = 0;
                end
            end
        end
        @(posedge clk);
        for (int md = 0; md < 2; md++) begin
            m_valid[md] = n_valid[md];
            m_data[md]  = n_data[md];
            m_sel[md]   = n_sel[md];
            m_ptr[md]   = n_ptr[md];
        end
        #1;
    endtask

    initial begin
        tbl[0]  = '{3'b111, 1'b1, 1'b0, D0, 3'b001, 1'b1, 2'd0, 8'h11};
        tbl[1]  = '{3'b111, 1'b1, 1'b0, D0, 3'b010, 1'b1, 2'd1, 8'h22};
        tbl[2]  = '{3'b111, 1'b1, 1'b0, D0, 3'b100, 1'b1, 2'd2, 8'h33};
        tbl[3]  = '{3'b111, 1'b1, 1'b0, D0, 3'b001, 1'b1, 2'd0, 8'h11};
        tbl[4]  = '{3'b101, 1'b1, 1'b0, D0, 3'b100, 1'b1, 2'd2, 8'h33};
        tbl[5]  = '{3'b001, 1'b1, 1'b0, D0, 3'b001, 1'b1, 2'd0, 8'h11};
        tbl[6]  = '{3'b010, 1'b1, 1'b0, D1, 3'b010, 1'b1, 2'd1, 8'hAA};
        tbl[7]  = '{3'b111, 1'b0, 1'b0, D1, 3'b000, 1'b1, 2'd1, 8'hAA};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, D1, 3'b000, 1'b1, 2'd1, 8'hAA};
        tbl[9]  = '{3'b111, 1'b0, 1'b0, D1, 3'b000, 1'b1, 2'd1, 8'hAA};
        tbl[10] = '{3'b111, 1'b0, 1'b0, D1, 3'b000, 1'b1, 2'd1, 8'hAA};
        tbl[11] = '{3'b001, 1'b1, 1'b1, D1, 3'b000, 1'b0, 2'd1, 8'hAA};
        tbl[12] = '{3'b111, 1'b1, 1'b0, D1, 3'b100, 1'b1, 2'd2, 8'h33};
        tbl[13] = '{3'b000, 1'b1, 1'b0, D1, 3'b000, 1'b0, 2'd2, 8'h33};
        tbl[14] = '{3'b000, 1'b0, 1'b0, D1, 3'b000, 1'b0, 2'd2, 8'h33};

        rst   = 1'b0;
        vin   = 3'b111;
        rdy   = 1'b1;
        flush = 1'b0;
        din   = D0;
        model_reset();

        #3;
        chk("reset valid_o", 32'(vout1), 32'd0);
        chk("reset data_o", 32'(dout1), 32'd0);
        chk("reset sel_o", 32'(sel1), 32'd0);
        chk("reset ready_o", 32'(ready1), 32'd0);
        chk("reset fp valid_o", 32'(vout0), 32'd0);
        chk("reset fp ready_o", 32'(ready0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            vin   = tbl[i].v;
            rdy   = tbl[i].r;
            flush = tbl[i].f;
            din   = tbl[i].d;
            tick();
            chk($sformatf("vec%0d ready_o", i), 32'(smp_ready1), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d valid_o", i), 32'(vout1), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d sel_o", i), 32'(sel1), 32'(tbl[i].e_sel));
            chk($sformatf("vec%0d data_o", i), 32'(dout1), 32'(tbl[i].e_data));
        end

        // Fixed priority never reaches channel 2 while channel 1 requests.
        vin   = 3'b110;
        rdy   = 1'b1;
        flush = 1'b0;
        din   = D0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fp beat%0d ready_o", i), 32'(smp_ready0), 32'(3'b010));
            chk($sformatf("fp beat%0d sel_o", i), 32'(sel0), 32'd1);
            chk($sformatf("fp beat%0d valid_o", i), 32'(vout0), 32'd1);
        end

        for (int i = 0; i < 400; i++) begin
            vin   = 3'($urandom_range(0, 7));
            rdy   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            din   = 24'($urandom);
            tick();
        end

        // Asynchronous reset mid-stream.
        vin   = 3'b111;
        rdy   = 1'b1;
        flush = 1'b0;
        din   = D0;
        repeat (3) tick();
        #1;
        rst = 1'b0;
        #1;
        chk("async rst valid_o", 32'(vout1), 32'd0);
        chk("async rst data_o", 32'(dout1), 32'd0);
        chk("async rst sel_o", 32'(sel1), 32'd0);
        chk("async rst ready_o", 32'(ready1), 32'd0);
        chk("async rst fp valid_o", 32'(vout0), 32'd0);
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        chk("post rst ready_o", 32'(smp_ready1), 32'(3'b001));
        chk("post rst sel_o", 32'(sel1), 32'd0);
        chk("post rst data_o", 32'(dout1), 32'h11);
        chk("post rst valid_o", 32'(vout1), 32'd1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
